// File: rtl/uart_pkg.sv
// Shared serial-port definitions: SM mode encodings, bus register addresses
// and the receiver oversampling ratio.
package uart_pkg;

  typedef enum logic [1:0] {
    SM_MODE0 = 2'b00,
    SM_MODE1 = 2'b01,
    SM_MODE2 = 2'b10,
    SM_MODE3 = 2'b11
  } sm_e;

  localparam logic [7:0] BRL_ADDR  = 8'h8D;
  localparam logic [7:0] PCON_ADDR = 8'h87;
  localparam logic [7:0] RBUF_ADDR = 8'h98;

  localparam int OVERSAMPLE = 16;
  localparam int TCNT_W     = $clog2(OVERSAMPLE);

  // Modes 1 and 3 take their bit rate from the BRL reload counter.
  function automatic logic is_reload_mode(input sm_e sm);
    return (sm == SM_MODE1) || (sm == SM_MODE3);
  endfunction

endpackage

// File: rtl/baud_reload_counter.sv
// 8-bit up-counter that reloads from BRL on overflow; overflow marks the end
// of one oversampling period in the reload-driven serial modes.
module baud_reload_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [7:0] brl_i,
  output logic       ovf_o
);

  logic [7:0] cnt_q, cnt_d;

  // A load request wins over counting, so it never doubles as an overflow.
  assign ovf_o = en_i && !load_i && (cnt_q == 8'hFF);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = brl_i;
    end else if (en_i) begin
      cnt_d = ovf_o ? brl_i : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: div_clk oversampling strobe plus per-bit tick.
// Optional SMOD doubling bit in PCON is built only with UART_BAUD_SMOD_EN.
module uart_baud_gen #(
  parameter logic [7:0] BRL_ADDR  = uart_pkg::BRL_ADDR,
  parameter logic [7:0] PCON_ADDR = uart_pkg::PCON_ADDR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ab,
  input  logic [7:0] db_w,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] scon,
  output logic [7:0] db_r,
  output logic       div_clk,
  output logic       bit_tick
);

  import uart_pkg::*;

  sm_e               sm;
  sm_e               sm_q;
  logic              armed_q;
  logic [1:0]        pc_q, pc_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]        brl_q;
  logic              smod;
  logic              div_clk_q, bit_tick_q;
  logic              brl_we;
  logic              sm_change, reload_mode, pre_en, cnt_en, cnt_ovf;
  logic              fire, wrap;
  logic [5:0]        scon_unused;

  assign sm          = sm_e'(scon[7:6]);
  assign scon_unused = scon[5:0];

  assign brl_we = !wrn && (ab == BRL_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brl_q <= 8'h00;
    end else if (brl_we) begin
      brl_q <= db_w;
    end
  end

`ifdef UART_BAUD_SMOD_EN
  logic smod_q;
  logic pcon_we;

  assign pcon_we = !wrn && (ab == PCON_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smod_q <= 1'b0;
    end else if (pcon_we) begin
      smod_q <= db_w[7];
    end
  end

  assign smod = smod_q;
`else
  assign smod = 1'b0;
`endif

  // armed_q keeps the first clk after reset from looking like a mode change,
  // so the first period after reset is a full period of the selected mode.
  assign sm_change   = armed_q && (sm != sm_q);
  assign reload_mode = is_reload_mode(sm);
  assign pre_en      = smod || pc_q[0];
  assign cnt_en      = reload_mode && pre_en && !sm_change;

  baud_reload_counter u_reload (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (cnt_en),
    .load_i (sm_change),
    .brl_i  (brl_q),
    .ovf_o  (cnt_ovf)
  );

  always_comb begin
    fire = 1'b0;
    case (sm)
      SM_MODE0: fire = 1'b1;
      SM_MODE2: fire = smod ? pc_q[0] : (pc_q == 2'b11);
      default:  fire = cnt_ovf;
    endcase
    if (sm_change) begin
      fire = 1'b0;
    end
  end

  assign wrap = fire && (tcnt_q == TCNT_W'(OVERSAMPLE - 1));

  always_comb begin
    pc_d   = pc_q + 2'd1;
    tcnt_d = tcnt_q;
    if (sm_change) begin
      pc_d   = 2'd0;
      tcnt_d = '0;
    end else if (fire) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_q       <= SM_MODE0;
      armed_q    <= 1'b0;
      pc_q       <= 2'd0;
      tcnt_q     <= '0;
      div_clk_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      sm_q       <= sm;
      armed_q    <= 1'b1;
      pc_q       <= pc_d;
      tcnt_q     <= tcnt_d;
      div_clk_q  <= fire;
      bit_tick_q <= wrap;
    end
  end

  // Unselected reads return zero so this slave can be OR-merged on db_r.
  always_comb begin
    db_r = 8'h00;
    if (!rdn && (ab == BRL_ADDR)) begin
      db_r = brl_q;
    end else if (!rdn && (ab == PCON_ADDR)) begin
      db_r = {smod, 7'b0};
    end
  end

  assign div_clk  = div_clk_q;
  assign bit_tick = bit_tick_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: table of mode/reload vectors plus
// directed sequences for reset, mid-count BRL writes and mode switches.
module tb_uart_baud_gen;

  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ab = 8'h00;
  logic [7:0] db_w = 8'h00;
  logic       wrn = 1'b1;
  logic       rdn = 1'b1;
  logic [7:0] scon = 8'h00;
  logic [7:0] db_r;
  logic       div_clk;
  logic       bit_tick;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  uart_baud_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ab       (ab),
    .db_w     (db_w),
    .wrn      (wrn),
    .rdn      (rdn),
    .scon     (scon),
    .db_r     (db_r),
    .div_clk  (div_clk),
    .bit_tick (bit_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] sm;
    logic       smod;
    logic [7:0] brl;
    int         per_en;
    int         per_dis;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Bus tasks are entered and left right after a falling edge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    ab = a;
    db_w = d;
    wrn = 1'b0;
    @(negedge clk);
    wrn = 1'b1;
    ab = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output int d);
    ab = a;
    rdn = 1'b0;
    #1;
    d = int'(db_r);
    rdn = 1'b1;
    ab = 8'h00;
  endtask

  task automatic next_strobe(input int budget, output int at);
    int n;
    n = 0;
    at = -1;
    do begin
      @(negedge clk);
      n++;
      if (div_clk) at = cyc;
    end while (at < 0 && n < budget);
  endtask

  int   p, first, second, btk, btk2, ndiv, rd, s0, t1, t2, t3, t4, nhi;
  logic [7:0] pcon_exp;

  initial begin
    vt[0] = '{sm: 2'b01, smod: 1'b0, brl: 8'hFD, per_en: 6,  per_dis: 6};
    vt[1] = '{sm: 2'b01, smod: 1'b1, brl: 8'hFD, per_en: 3,  per_dis: 6};
    vt[2] = '{sm: 2'b10, smod: 1'b1, brl: 8'h00, per_en: 2,  per_dis: 4};
    vt[3] = '{sm: 2'b10, smod: 1'b0, brl: 8'h00, per_en: 4,  per_dis: 4};
    vt[4] = '{sm: 2'b11, smod: 1'b1, brl: 8'hF0, per_en: 16, per_dis: 32};
    vt[5] = '{sm: 2'b11, smod: 1'b1, brl: 8'hFF, per_en: 1,  per_dis: 2};
    vt[6] = '{sm: 2'b01, smod: 1'b0, brl: 8'hFE, per_en: 4,  per_dis: 4};
`ifdef UART_BAUD_SMOD_EN
    pcon_exp = 8'h80;
`else
    pcon_exp = 8'h00;
`endif

    // Reset state and mode 0
    repeat (3) @(negedge clk);
    chk("rst_div_clk", int'(div_clk), 0);
    chk("rst_bit_tick", int'(bit_tick), 0);
    chk("rst_db_r", int'(db_r), 0);
    rst_n = 1'b1;
    first = -1; btk = -1; btk2 = -1; ndiv = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (div_clk) begin
        ndiv++;
        if (first < 0) first = i;
      end
      if (bit_tick) begin
        if (btk < 0) btk = i;
        else if (btk2 < 0) btk2 = i;
      end
    end
    chk("m0_first_div", first, 1);
    chk("m0_div_count", ndiv, 32);
    chk("m0_first_bit", btk, 16);
    chk("m0_second_bit", btk2, 32);
    bus_read(BRL_ADDR, rd);
    chk("rst_brl_read", rd, 0);
    bus_read(PCON_ADDR, rd);
    chk("rst_pcon_read", rd, 0);

    // Mode 1 from reset values, then BRL write in the middle of a period
    rst_n = 1'b0;
    scon = {2'b01, 6'b000000};
    @(negedge clk);
    rst_n = 1'b1;
    s0 = cyc;
    next_strobe(600, t1);
    chk("m1_rst_first", t1 - s0, 512);
    repeat (256) @(negedge clk);
    bus_write(BRL_ADDR, 8'hF0);
    next_strobe(600, t2);
    chk("brl_mid_cur_period", t2 - t1, 512);
    next_strobe(100, t3);
    chk("brl_mid_new_period1", t3 - t2, 32);
    next_strobe(100, t4);
    chk("brl_mid_new_period2", t4 - t3, 32);

    // Table: switch from mode 0 into each configuration and time the strobes
    for (int v = 0; v < 7; v++) begin
      scon = 8'h00;
      repeat (3) @(negedge clk);
      bus_write(BRL_ADDR, vt[v].brl);
      bus_write(PCON_ADDR, {vt[v].smod, 7'b0});
`ifdef UART_BAUD_SMOD_EN
      p = vt[v].per_en;
`else
      p = vt[v].per_dis;
`endif
      scon = {vt[v].sm, 6'b101010};
      first = -1; second = -1; btk = -1; ndiv = 0;
      for (int i = 1; i <= 1 + 16 * p; i++) begin
        @(negedge clk);
        if (div_clk) begin
          ndiv++;
          if (first < 0) first = i;
          else if (second < 0) second = i;
        end
        if (bit_tick && btk < 0) btk = i;
      end
      chk($sformatf("vec%0d_first_div", v), first, 1 + p);
      chk($sformatf("vec%0d_period", v), second - first, p);
      chk($sformatf("vec%0d_bit_tick", v), btk, 1 + 16 * p);
      chk($sformatf("vec%0d_div_count", v), ndiv, 16);
    end

    // Readback and bus isolation
    bus_write(BRL_ADDR, 8'hA5);
    bus_read(BRL_ADDR, rd);
    chk("brl_readback", rd, 8'hA5);
    bus_read(RBUF_ADDR, rd);
    chk("rbuf_isolation", rd, 0);
    ab = BRL_ADDR;
    rdn = 1'b1;
    #1;
    chk("rdn_high_isolation", int'(db_r), 0);
    ab = 8'h00;
    bus_write(PCON_ADDR, 8'hFF);
    bus_read(PCON_ADDR, rd);
    chk("pcon_readback", rd, int'(pcon_exp));
    bus_write(PCON_ADDR, 8'h00);

    // Mode switch 01 -> 00: no strobe on the switch clk, then every clk
    bus_write(BRL_ADDR, 8'hFD);
    scon = {2'b01, 6'b000000};
    next_strobe(100, t1);
    @(negedge clk);
    scon = 8'h00;
    @(negedge clk);
    chk("sw_no_strobe", int'(div_clk), 0);
    nhi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (div_clk) nhi++;
    end
    chk("sw_every_clk", nhi, 5);

    // Asynchronous reset in the middle of operation
    chk("pre_rst_div_high", int'(div_clk), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_div", int'(div_clk), 0);
    chk("async_rst_bit", int'(bit_tick), 0);
    ab = BRL_ADDR;
    rdn = 1'b0;
    #1;
    chk("async_rst_brl", int'(db_r), 0);
    rdn = 1'b1;
    ab = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
